// File: rtl/call_request_dispatcher_pkg.sv
// Shared types and constants for the hall-call dispatcher and the car controllers.
package call_request_dispatcher_pkg;

    localparam int FLOOR_W    = 3;
    localparam int WEIGHT_W   = 11;
    localparam int NUM_FLOORS = 7;

    // Floor 0 is never a legal destination; car controllers treat it as "no floor".
    localparam logic [FLOOR_W-1:0] FLOOR_INVALID = '0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    // Round-robin pick: first set bit searching upward from last+1, wrapping 7 -> 1.
    function automatic logic [FLOOR_W-1:0] next_floor(
        input logic [NUM_FLOORS:0] pend,
        input logic [FLOOR_W-1:0]  last
    );
        logic [FLOOR_W-1:0] pick;
        logic [FLOOR_W-1:0] cand;
        pick = FLOOR_INVALID;
        for (int i = NUM_FLOORS; i >= 1; i--) begin
            cand = FLOOR_W'((int'(last) + i - 1) % NUM_FLOORS + 1);
            if (pend[cand]) begin
                pick = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/call_request_dispatcher_debounce.sv
// Per-floor button debouncer: one-cycle accept pulse once the button has been
// high for DEBOUNCE_CYCLES consecutive cycles; re-arms only after release.
module call_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic accept
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] cnt_reg;

    // The counter saturates, so the pulse fires only on the step into CNT_MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            accept  <= 1'b0;
        end else begin
            accept <= btn && (cnt_reg == CNT_MAX - 1'b1);
            if (!btn) begin
                cnt_reg <= '0;
            end else if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/call_request_dispatcher.sv
// Latches debounced hall calls and issues them round-robin to the car controller,
// re-issuing on timeout and abandoning a floor after MAX_RETRY re-issues.
module call_request_dispatcher
    import call_request_dispatcher_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int MAX_RETRY       = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          call_btn,
    input  logic [WEIGHT_W-1:0] weight_in,
    output logic [FLOOR_W-1:0]  req_floor,
    output logic [WEIGHT_W-1:0] req_weight,
    output logic                req_valid,
    input  logic                req_ready,
    input  logic                served,
    input  logic [FLOOR_W-1:0]  served_floor,
    output logic [7:0]          pending,
    output logic                dropped,
    output logic                busy
);

    localparam int               TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int               RT_W    = $clog2(MAX_RETRY) + 1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RT_W-1:0]  RT_MAX  = RT_W'(MAX_RETRY);

    state_t               state_reg;
    logic [7:0]           pending_reg;
    logic [NUM_FLOORS:0]  accept;
    logic [FLOOR_W-1:0]   last_floor_reg;
    logic [TO_W-1:0]      timeout_reg;
    logic [RT_W-1:0]      retry_reg;
    logic [7:0]           clr_mask;
    logic                 served_hit_req;
    logic                 drop_now;

    assign accept[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi <= NUM_FLOORS; gi++) begin : g_floor
            call_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .rst    (rst),
                .btn    (call_btn[gi]),
                .accept (accept[gi])
            );
        end
    endgenerate

    assign served_hit_req = served && (served_floor == req_floor);
    assign drop_now = (state_reg == WAIT) && !served_hit_req &&
                      (timeout_reg == TO_LAST) && (retry_reg >= RT_MAX);

    always_comb begin
        clr_mask = '0;
        if (served && served_floor != FLOOR_INVALID) begin
            clr_mask[served_floor] = 1'b1;
        end
        if (drop_now) begin
            clr_mask[req_floor] = 1'b1;
        end
    end

    // Clears take priority over a press accepted in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= (pending_reg | accept) & ~clr_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            req_floor      <= FLOOR_INVALID;
            req_weight     <= '0;
            req_valid      <= 1'b0;
            dropped        <= 1'b0;
            last_floor_reg <= FLOOR_W'(NUM_FLOORS);
            timeout_reg    <= '0;
            retry_reg      <= '0;
        end else begin
            dropped <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|pending_reg) begin
                        state_reg  <= ISSUE;
                        req_floor  <= next_floor(pending_reg, last_floor_reg);
                        req_weight <= weight_in;
                        retry_reg  <= '0;
                        req_valid  <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Withdraw if the floor was served (or cleared on the way in) before the handshake.
                    if (served_hit_req || !pending_reg[req_floor]) begin
                        req_valid <= 1'b0;
                        state_reg <= IDLE;
                    end else if (req_ready) begin
                        req_valid      <= 1'b0;
                        state_reg      <= WAIT;
                        last_floor_reg <= req_floor;
                        timeout_reg    <= '0;
                    end
                end
                WAIT: begin
                    if (served_hit_req) begin
                        state_reg <= IDLE;
                    end else if (timeout_reg == TO_LAST) begin
                        if (retry_reg < RT_MAX) begin
                            retry_reg  <= retry_reg + 1'b1;
                            state_reg  <= ISSUE;
                            req_valid  <= 1'b1;
                            req_weight <= weight_in;
                        end else begin
                            dropped   <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end else begin
                        timeout_reg <= timeout_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign pending = pending_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_call_request_dispatcher.sv
// Directed scenarios followed by a randomized phase, checked against a
// behavioural model of the pending-call set and the request protocol.
module tb_call_request_dispatcher;

    localparam int DB = 4;
    localparam int TO = 64;
    localparam int MR = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  call_btn;
    logic [10:0] weight_in;
    logic [2:0]  req_floor;
    logic [10:0] req_weight;
    logic        req_valid;
    logic        req_ready;
    logic        served;
    logic [2:0]  served_floor;
    logic [7:0]  pending;
    logic        dropped;
    logic        busy;

    int          vectors = 0;
    int          miscompares = 0;
    int          run_m [8];
    logic [7:0]  pend_m;
    logic [7:0]  acc_m;
    int          drop_m;
    int          order [3] = '{6, 2, 4};

    call_request_dispatcher #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRY      (MR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .call_btn     (call_btn),
        .weight_in    (weight_in),
        .req_floor    (req_floor),
        .req_weight   (req_weight),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .served       (served),
        .served_floor (served_floor),
        .pending      (pending),
        .dropped      (dropped),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend_m = '0;
        acc_m  = '0;
        drop_m = 0;
        for (int n = 0; n < 8; n++) run_m[n] = 0;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        @(posedge clk);
        pend_m = pend_m | acc_m;
        if (served && served_floor != 3'd0) pend_m[served_floor] = 1'b0;
        if (drop_m != 0) begin
            pend_m[drop_m] = 1'b0;
            drop_m = 0;
        end
        acc_m = '0;
        for (int n = 1; n < 8; n++) begin
            if (call_btn[n]) begin
                run_m[n]++;
                if (run_m[n] == DB) acc_m[n] = 1'b1;
            end else begin
                run_m[n] = 0;
            end
        end
        #1;
        check("pending", {24'b0, pending}, {24'b0, pend_m});
        check("valid_floor_nonzero", {31'b0, req_valid && req_floor == 3'd0}, 32'd0);
        check("busy_when_valid", {31'b0, req_valid && !busy}, 32'd0);
    endtask

    task automatic press(input logic [7:0] mask);
        call_btn = mask;
        repeat (DB) step();
        call_btn = '0;
    endtask

    task automatic wait_valid(input int budget);
        int c;
        c = 0;
        while (!req_valid && c < budget) begin
            step();
            c++;
        end
        check("wait_valid_timeout", {31'b0, req_valid}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        call_btn = '0;
        weight_in = '0;
        req_ready = 1'b0;
        served = 1'b0;
        served_floor = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, req_valid}, 32'd0);
        check("rst_pending", {24'b0, pending}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_floor", {29'b0, req_floor}, 32'd0);
        check("rst_weight", {21'b0, req_weight}, 32'd0);
        check("rst_dropped", {31'b0, dropped}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single call on floor 5
        weight_in = 11'd300;
        req_ready = 1'b1;
        press(8'h20);
        step();
        check("r22_pending", {24'b0, pending}, 32'h20);
        wait_valid(8);
        check("r22_floor", {29'b0, req_floor}, 32'd5);
        check("r22_weight", {21'b0, req_weight}, 32'd300);
        step();
        check("r22_wait_valid", {31'b0, req_valid}, 32'd0);
        check("r22_wait_busy", {31'b0, busy}, 32'd1);
        served = 1'b1; served_floor = 3'd5;
        step();
        served = 1'b0;
        check("r22_done_pending", {24'b0, pending}, 32'd0);
        check("r22_done_busy", {31'b0, busy}, 32'd0);

        // Leave last_floor at 4, then round-robin over 2, 4, 6
        press(8'h10);
        wait_valid(10);
        check("r23_setup_floor", {29'b0, req_floor}, 32'd4);
        step();
        served = 1'b1; served_floor = 3'd4;
        step();
        served = 1'b0;
        press(8'h54);
        for (int i = 0; i < 3; i++) begin
            wait_valid(10);
            check("r23_order", {29'b0, req_floor}, order[i]);
            step();
            repeat (5) begin
                step();
                check("r23_hold_wait", {31'b0, req_valid}, 32'd0);
            end
            served = 1'b1; served_floor = 3'(order[i]);
            step();
            served = 1'b0;
        end
        check("r23_pending_empty", {24'b0, pending}, 32'd0);

        // Floor 3 withheld by req_ready, then served before handshake
        req_ready = 1'b0;
        weight_in = 11'd100;
        press(8'h08);
        wait_valid(10);
        check("r24_floor", {29'b0, req_floor}, 32'd3);
        weight_in = 11'd222;
        repeat (10) begin
            step();
            check("r24_hold_valid", {31'b0, req_valid}, 32'd1);
            check("r24_hold_floor", {29'b0, req_floor}, 32'd3);
            check("r24_hold_weight", {21'b0, req_weight}, 32'd100);
        end
        served = 1'b1; served_floor = 3'd3;
        step();
        served = 1'b0;
        check("r24_withdrawn", {31'b0, req_valid}, 32'd0);
        check("r24_idle", {31'b0, busy}, 32'd0);
        req_ready = 1'b1;

        // Glitch, then press accepted in the same cycle as served(1)
        call_btn = 8'h02;
        repeat (3) step();
        call_btn = '0;
        step();
        check("r26_glitch", {24'b0, pending}, 32'd0);
        press(8'h02);
        served = 1'b1; served_floor = 3'd1;
        step();
        served = 1'b0;
        check("r26_clear_wins", {31'b0, pending[1]}, 32'd0);
        step();
        check("r26_idle", {31'b0, busy}, 32'd0);

        // Floor 7 never served: three re-issues, then dropped
        weight_in = 11'd50;
        press(8'h80);
        wait_valid(10);
        check("r25_floor", {29'b0, req_floor}, 32'd7);
        check("r25_weight0", {21'b0, req_weight}, 32'd50);
        for (int i = 0; i <= MR; i++) begin
            step();
            check("r25_handshake", {31'b0, req_valid}, 32'd0);
            weight_in = 11'(400 + i);
            for (int k = 1; k <= TO; k++) begin
                if (k == TO && i == MR) drop_m = 7;
                step();
                if (k == TO - 1) check("r25_early", {31'b0, req_valid | dropped}, 32'd0);
            end
            if (i < MR) begin
                check("r25_reissue_valid", {31'b0, req_valid}, 32'd1);
                check("r25_reissue_floor", {29'b0, req_floor}, 32'd7);
                check("r25_reissue_weight", {21'b0, req_weight}, 32'(400 + i));
                check("r25_no_drop", {31'b0, dropped}, 32'd0);
            end else begin
                check("r25_dropped", {31'b0, dropped}, 32'd1);
                check("r25_drop_valid", {31'b0, req_valid}, 32'd0);
                check("r25_drop_pending7", {31'b0, pending[7]}, 32'd0);
            end
        end
        step();
        check("r25_drop_pulse", {31'b0, dropped}, 32'd0);
        check("r25_idle", {31'b0, busy}, 32'd0);

        // Reset while floor 4 is being offered
        req_ready = 1'b0;
        press(8'h10);
        wait_valid(10);
        check("r27_floor", {29'b0, req_floor}, 32'd4);
        rst = 1'b1;
        #1;
        check("r27_valid", {31'b0, req_valid}, 32'd0);
        check("r27_pending", {24'b0, pending}, 32'd0);
        check("r27_busy", {31'b0, busy}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int n = 1; n < 8; n++) begin
                if ($urandom_range(0, 9) == 0) call_btn[n] = ~call_btn[n];
            end
            call_btn[0] = 1'($urandom_range(0, 1));
            req_ready = ($urandom_range(0, 2) != 0);
            weight_in = 11'($urandom_range(0, 2047));
            served = ($urandom_range(0, 5) == 0);
            served_floor = ($urandom_range(0, 1) != 0) ? req_floor : 3'($urandom_range(0, 7));
            step();
        end
        call_btn = '0;
        served = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
